// File: rtl/regbank_fwd_stage.sv
// Register bank with an operand-fetch stage. It resolves RAW hazards
// against the EX, DM and WB results and registers the A/B operands for execute.
module regbank_fwd_stage #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_rd,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] ans_wb,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              op_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] SRC_FILE = 2'd0;
  localparam logic [1:0] SRC_EX   = 2'd1;
  localparam logic [1:0] SRC_DM   = 2'd2;
  localparam logic [1:0] SRC_WB   = 2'd3;

  logic [DATA_W-1:0] regs [DEPTH];

  logic              file_we_c;
  logic [DATA_W-1:0] a_val_c;
  logic [DATA_W-1:0] b_val_c;
  logic [1:0]        a_code_c;
  logic [1:0]        b_code_c;

  // r0 is hard-wired to zero when ZERO_REG is set, so writes to it are dropped
  assign file_we_c = wb_we && !(ZERO_REG && (wb_rd == '0));

  // Register file write port (WB only); it ignores stall and flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (file_we_c) begin
      regs[wb_rd] <= ans_wb;
    end
  end

  // Operand A source select: r0, then EX, then DM, then WB, then the file
  always_comb begin
    a_val_c  = regs[rs_a];
    a_code_c = SRC_FILE;
    if (ZERO_REG && (rs_a == '0)) begin
      a_val_c  = '0;
      a_code_c = SRC_FILE;
    end else if (ex_we && (ex_rd == rs_a)) begin
      a_val_c  = ans_ex;
      a_code_c = SRC_EX;
    end else if (dm_we && (dm_rd == rs_a)) begin
      a_val_c  = ans_dm;
      a_code_c = SRC_DM;
    end else if (wb_we && (wb_rd == rs_a)) begin
      a_val_c  = ans_wb;
      a_code_c = SRC_WB;
    end
  end

  // Operand B source select: the immediate overrides the register path
  always_comb begin
    b_val_c  = regs[rs_b];
    b_code_c = SRC_FILE;
    if (imm_sel) begin
      b_val_c  = imm;
      b_code_c = SRC_FILE;
    end else if (ZERO_REG && (rs_b == '0)) begin
      b_val_c  = '0;
      b_code_c = SRC_FILE;
    end else if (ex_we && (ex_rd == rs_b)) begin
      b_val_c  = ans_ex;
      b_code_c = SRC_EX;
    end else if (dm_we && (dm_rd == rs_b)) begin
      b_val_c  = ans_dm;
      b_code_c = SRC_DM;
    end else if (wb_we && (wb_rd == rs_b)) begin
      b_val_c  = ans_wb;
      b_code_c = SRC_WB;
    end
  end

  // Operand stage register: flush beats stall, and stall beats load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A        <= '0;
      B        <= '0;
      fwd_a    <= SRC_FILE;
      fwd_b    <= SRC_FILE;
      op_valid <= 1'b0;
    end else if (flush) begin
      A        <= '0;
      B        <= '0;
      fwd_a    <= SRC_FILE;
      fwd_b    <= SRC_FILE;
      op_valid <= 1'b0;
    end else if (!stall) begin
      A        <= a_val_c;
      B        <= b_val_c;
      fwd_a    <= a_code_c;
      fwd_b    <= b_code_c;
      op_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regbank_fwd_stage.sv
// Directed bench for regbank_fwd_stage. It uses a vector table plus short
// hand sequences for reset, async clear and a narrow/wide parameter set.
module tb_regbank_fwd_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: DATA_W=8, ADDR_W=5, ZERO_REG=1
  logic       rst_n;
  logic [4:0] rs_a, rs_b, ex_rd, dm_rd, wb_rd;
  logic [7:0] imm, ans_ex, ans_dm, ans_wb;
  logic       imm_sel, stall, flush, ex_we, dm_we, wb_we;
  logic [7:0] A, B;
  logic [1:0] fwd_a, fwd_b;
  logic       op_valid;

  regbank_fwd_stage u_dut (
    .clk(clk), .rst_n(rst_n), .rs_a(rs_a), .rs_b(rs_b), .imm(imm),
    .imm_sel(imm_sel), .stall(stall), .flush(flush),
    .ex_we(ex_we), .ex_rd(ex_rd), .ans_ex(ans_ex),
    .dm_we(dm_we), .dm_rd(dm_rd), .ans_dm(ans_dm),
    .wb_we(wb_we), .wb_rd(wb_rd), .ans_wb(ans_wb),
    .A(A), .B(B), .fwd_a(fwd_a), .fwd_b(fwd_b), .op_valid(op_valid)
  );

  // Second instance: DATA_W=16, ADDR_W=3
  logic        rst2_n;
  logic [2:0]  rs_a2, rs_b2, ex_rd2, dm_rd2, wb_rd2;
  logic [15:0] imm2, ans_ex2, ans_dm2, ans_wb2;
  logic        imm_sel2, stall2, flush2, ex_we2, dm_we2, wb_we2;
  logic [15:0] A2, B2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic        op_valid2;

  regbank_fwd_stage #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .rs_a(rs_a2), .rs_b(rs_b2), .imm(imm2),
    .imm_sel(imm_sel2), .stall(stall2), .flush(flush2),
    .ex_we(ex_we2), .ex_rd(ex_rd2), .ans_ex(ans_ex2),
    .dm_we(dm_we2), .dm_rd(dm_rd2), .ans_dm(ans_dm2),
    .wb_we(wb_we2), .wb_rd(wb_rd2), .ans_wb(ans_wb2),
    .A(A2), .B(B2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .op_valid(op_valid2)
  );

  typedef struct packed {
    logic [4:0] rs_a;
    logic [4:0] rs_b;
    logic [7:0] imm;
    logic       imm_sel;
    logic       stall;
    logic       flush;
    logic       ex_we;
    logic [4:0] ex_rd;
    logic [7:0] ans_ex;
    logic       dm_we;
    logic [4:0] dm_rd;
    logic [7:0] ans_dm;
    logic       wb_we;
    logic [4:0] wb_rd;
    logic [7:0] ans_wb;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [1:0] exp_fa;
    logic [1:0] exp_fb;
    logic       exp_v;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  int errors = 0;
  int checks = 0;

  function automatic vec_t row(
    input int ra, input int rb, input int im, input int isel,
    input int st, input int fl,
    input int exw, input int exr, input int exv,
    input int dmw, input int dmr, input int dmv,
    input int wbw, input int wbr, input int wbv,
    input int ea, input int eb, input int efa, input int efb, input int ev);
    vec_t r;
    r.rs_a = 5'(ra);  r.rs_b = 5'(rb);  r.imm = 8'(im);
    r.imm_sel = 1'(isel); r.stall = 1'(st); r.flush = 1'(fl);
    r.ex_we = 1'(exw); r.ex_rd = 5'(exr); r.ans_ex = 8'(exv);
    r.dm_we = 1'(dmw); r.dm_rd = 5'(dmr); r.ans_dm = 8'(dmv);
    r.wb_we = 1'(wbw); r.wb_rd = 5'(wbr); r.ans_wb = 8'(wbv);
    r.exp_a = 8'(ea); r.exp_b = 8'(eb);
    r.exp_fa = 2'(efa); r.exp_fb = 2'(efb); r.exp_v = 1'(ev);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs_a = v.rs_a; rs_b = v.rs_b; imm = v.imm; imm_sel = v.imm_sel;
    stall = v.stall; flush = v.flush;
    ex_we = v.ex_we; ex_rd = v.ex_rd; ans_ex = v.ans_ex;
    dm_we = v.dm_we; dm_rd = v.dm_rd; ans_dm = v.ans_dm;
    wb_we = v.wb_we; wb_rd = v.wb_rd; ans_wb = v.ans_wb;
  endtask

  initial begin
    //                ra  rb  imm  is st fl  exw exr exv   dmw dmr dmv   wbw wbr wbv    A     B    fa fb v
    vecs[0]  = row( 1,  2,  0,   0, 0, 0,  0, 0,  0,     0, 0, 0,      1, 7, 'hD0,   0,    0,    0, 0, 1);
    vecs[1]  = row( 7,  0,  0,   0, 0, 0,  0, 0,  0,     0, 0, 0,      0, 0, 0,      'hD0, 0,    0, 0, 1);
    vecs[2]  = row( 3,  3,  0,   0, 0, 0,  1, 3,  'hC0,  1, 3, 'hD0,   1, 3, 'hE0,   'hC0, 'hC0, 1, 1, 1);
    vecs[3]  = row( 3,  7,  0,   0, 0, 0,  0, 3,  'hC0,  1, 3, 'hD0,   1, 3, 'hE0,   'hD0, 'hD0, 2, 0, 1);
    vecs[4]  = row( 3,  3,  'h5A,1, 0, 0,  0, 3,  'hC0,  0, 3, 'hD0,   1, 3, 'hE0,   'hE0, 'h5A, 3, 0, 1);
    vecs[5]  = row( 0,  0,  0,   0, 0, 0,  1, 0,  'h77,  0, 0, 0,      1, 0, 'hFF,   0,    0,    0, 0, 1);
    vecs[6]  = row( 0,  3,  0,   0, 0, 0,  0, 0,  0,     0, 0, 0,      0, 0, 0,      0,    'hE0, 0, 0, 1);
    vecs[7]  = row( 5,  5,  'hFF,1, 0, 0,  1, 5,  'h12,  0, 0, 0,      0, 0, 0,      'h12, 'hFF, 1, 0, 1);
    vecs[8]  = row( 9,  7,  0,   0, 0, 0,  0, 0,  0,     0, 0, 0,      1, 9, 'h11,   'h11, 'hD0, 3, 0, 1);
    vecs[9]  = row( 7,  3,  0,   0, 1, 0,  0, 0,  0,     0, 0, 0,      1, 10,'h44,   'h11, 'hD0, 3, 0, 1);
    vecs[10] = row( 3,  3,  0,   0, 1, 0,  1, 3,  'h99,  0, 0, 0,      0, 0, 0,      'h11, 'hD0, 3, 0, 1);
    vecs[11] = row(10,  0,  0,   0, 1, 0,  0, 0,  0,     0, 0, 0,      0, 0, 0,      'h11, 'hD0, 3, 0, 1);
    vecs[12] = row(10,  9,  0,   0, 0, 0,  0, 0,  0,     0, 0, 0,      0, 0, 0,      'h44, 'h11, 0, 0, 1);
    vecs[13] = row( 7,  7,  0,   0, 1, 1,  0, 0,  0,     0, 0, 0,      0, 0, 0,      0,    0,    0, 0, 0);
    vecs[14] = row( 7,  7,  0,   0, 1, 0,  0, 0,  0,     0, 0, 0,      0, 0, 0,      0,    0,    0, 0, 0);
    vecs[15] = row( 7, 10,  0,   0, 0, 0,  0, 0,  0,     0, 0, 0,      0, 0, 0,      'hD0, 'h44, 0, 0, 1);
    vecs[16] = row( 7, 10,  0,   0, 0, 1,  0, 0,  0,     0, 0, 0,      1, 20,'h5C,   0,    0,    0, 0, 0);
    vecs[17] = row( 3, 19,  0,   0, 0, 0,  1, 19, 'hAA,  0, 0, 0,      0, 0, 0,      'hE0, 'hAA, 0, 1, 1);
    vecs[18] = row(31, 31,  0,   0, 0, 0,  0, 0,  0,     0, 0, 0,      1, 31,'h3C,   'h3C, 'h3C, 3, 3, 1);
    vecs[19] = row(31, 20,  0,   0, 0, 0,  0, 0,  0,     0, 0, 0,      0, 0, 0,      'h3C, 'h5C, 0, 0, 1);

    drive(row(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rs_a2 = '0; rs_b2 = '0; imm2 = '0; imm_sel2 = 1'b0; stall2 = 1'b0; flush2 = 1'b0;
    ex_we2 = 1'b0; ex_rd2 = '0; ans_ex2 = '0; dm_we2 = 1'b0; dm_rd2 = '0; ans_dm2 = '0;
    wb_we2 = 1'b0; wb_rd2 = '0; ans_wb2 = '0;
    rst_n = 1'b0;
    rst2_n = 1'b0;

    // Reset state
    #12;
    check("rst_A", 32'(A), 32'h0);
    check("rst_B", 32'(B), 32'h0);
    check("rst_fwd_a", 32'(fwd_a), 32'h0);
    check("rst_fwd_b", 32'(fwd_b), 32'h0);
    check("rst_op_valid", 32'(op_valid), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;

    // Table-driven vectors, applied in sequence (the file state carries over)
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_A", i), 32'(A), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_B", i), 32'(B), 32'(vecs[i].exp_b));
      check($sformatf("v%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].exp_fa));
      check($sformatf("v%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].exp_fb));
      check($sformatf("v%0d_op_valid", i), 32'(op_valid), 32'(vecs[i].exp_v));
    end

    // Wide/narrow instance: write r7=0xBEEF, then read it on both ports
    wb_we2 = 1'b1; wb_rd2 = 3'd7; ans_wb2 = 16'hBEEF;
    @(posedge clk); #1;
    wb_we2 = 1'b0; rs_a2 = 3'd7; rs_b2 = 3'd7;
    @(posedge clk); #1;
    check("p16_A", 32'(A2), 32'hBEEF);
    check("p16_B", 32'(B2), 32'hBEEF);
    check("p16_fwd_a", 32'(fwd_a2), 32'h0);
    check("p16_op_valid", 32'(op_valid2), 32'h1);
    #2 rst2_n = 1'b0;
    #1;
    check("p16_async_A", 32'(A2), 32'h0);
    check("p16_async_op_valid", 32'(op_valid2), 32'h0);

    // Async reset mid-stall with a pending write: clear now, and the write is lost
    drive(row(7,7,0,0,1,0,0,0,0,0,0,0,1,12,'h55,0,0,0,0,0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_A", 32'(A), 32'h0);
    check("arst_B", 32'(B), 32'h0);
    check("arst_op_valid", 32'(op_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    drive(row(12,7,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    check("arst_lost_write_r12", 32'(A), 32'h0);
    check("arst_cleared_r7", 32'(B), 32'h0);
    check("arst_reload_valid", 32'(op_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
